// File: rtl/mem_responder.sv
// Word-wide data memory behind the CPU's stalling memory interface: one access at a time,
// LATENCY wait states, fault reporting with ack, and a combinational debug read port.
module mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_ren,
    input  logic                  mem_wen,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           mem_dout,
    output logic [31:0]           mem_din,
    output logic                  mem_stall,
    output logic                  mem_ack,
    output logic                  mem_err,
    input  logic [ADDR_WIDTH-1:0] debug_addr,
    output logic [31:0]           debug_data
);
    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic                  fault_q, fault_d;
    logic [31:0]           din_q, din_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic                  ram_we;
    logic [31:0]           ram [2**ADDR_WIDTH];

    logic req;
    logic req_fault;

    assign req       = mem_ren | mem_wen;
    assign req_fault = (mem_addr[1:0] != 2'b00)
                     | (|mem_addr[31:ADDR_WIDTH+2])
                     | (mem_ren & mem_wen);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        fault_d   = fault_q;
        din_d     = din_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        ram_we    = 1'b0;
        mem_stall = 1'b0;

        case (state_q)
            IDLE: begin
                mem_stall = req;
                if (req) begin
                    idx_d   = mem_addr[ADDR_WIDTH+1:2];
                    wdata_d = mem_dout;
                    rd_d    = mem_ren;
                    wr_d    = mem_wen;
                    fault_d = req_fault;
                    cnt_d   = LAT;
                    state_d = (LAT == 4'd0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                mem_stall = 1'b1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // With zero wait states the commit edge is the acceptance edge, so use the _d copies.
        if (state_d == RESP && state_q != RESP) begin
            ack_d  = 1'b1;
            err_d  = fault_d;
            ram_we = wr_d & ~fault_d & rst;
            if (rd_d) begin
                din_d = fault_d ? 32'd0 : ram[idx_d];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            fault_q <= 1'b0;
            din_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            fault_q <= fault_d;
            din_q   <= din_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the RAM array has no reset; its contents survive rst and only the write enable is qualified by it.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[idx_d] <= wdata_d;
        end
    end

    assign mem_din    = din_q;
    assign mem_ack    = ack_q;
    assign mem_err    = err_q;
    assign debug_data = ram[debug_addr];

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (0, 2 and 5 wait states) driven in turn and
// checked every cycle against a cycle-count/array model, plus literal spot checks.
module tb_mem_responder;
    localparam int AW = 10;
    localparam int NL = 3;
    localparam int LATS [NL] = '{0, 2, 5};
    localparam int WORDS = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NL-1:0]         ren, wen, stall, ack, err;
    logic [NL-1:0][31:0]   addr, dout, din, dbg_data;
    logic [NL-1:0][AW-1:0] dbg_addr;

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < NL; g++) begin : lane
            mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LATS[g])) dut (
                .clk       (clk),
                .rst       (rst),
                .mem_ren   (ren[g]),
                .mem_wen   (wen[g]),
                .mem_addr  (addr[g]),
                .mem_dout  (dout[g]),
                .mem_din   (din[g]),
                .mem_stall (stall[g]),
                .mem_ack   (ack[g]),
                .mem_err   (err[g]),
                .debug_addr(dbg_addr[g]),
                .debug_data(dbg_data[g])
            );
        end
    endgenerate

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic string nm(input int l, input string s);
        return $sformatf("L%0d %s", LATS[l], s);
    endfunction

    function automatic bit is_fault(input logic [31:0] a, input logic r, input logic w);
        return (a % 4 != 0) || ((a / 4) >= WORDS) || (r && w);
    endfunction

    // Reference model: an accepted access occupies cycles t0..t0+LAT+1, commits at the end of t0+LAT.
    int            cyc = 0;
    bit            m_busy  [NL];
    int            m_t0    [NL];
    bit            m_rd    [NL];
    bit            m_wr    [NL];
    bit            m_flt   [NL];
    int            m_idx   [NL];
    logic [31:0]   m_wd    [NL];
    logic [31:0]   m_din   [NL];
    logic [31:0]   m_ram   [NL][WORDS];
    bit            m_known [NL][WORDS];

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                for (int l = 0; l < NL; l++) begin
                    m_busy[l] = 1'b0;
                    m_din[l]  = 32'd0;
                end
            end else begin
                for (int l = 0; l < NL; l++) begin
                    if (!m_busy[l] && (ren[l] || wen[l])) begin
                        m_busy[l] = 1'b1;
                        m_t0[l]   = cyc;
                        m_rd[l]   = ren[l];
                        m_wr[l]   = wen[l];
                        m_flt[l]  = is_fault(addr[l], ren[l], wen[l]);
                        m_idx[l]  = int'(addr[l] / 4) % WORDS;
                        m_wd[l]   = dout[l];
                    end
                    if (m_busy[l] && cyc - m_t0[l] == LATS[l]) begin
                        if (m_wr[l] && !m_flt[l]) begin
                            m_ram[l][m_idx[l]]   = m_wd[l];
                            m_known[l][m_idx[l]] = 1'b1;
                        end
                        if (m_rd[l]) m_din[l] = m_flt[l] ? 32'd0 : m_ram[l][m_idx[l]];
                    end else if (m_busy[l] && cyc - m_t0[l] == LATS[l] + 1) begin
                        m_busy[l] = 1'b0;
                    end
                end
                cyc++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int l = 0; l < NL; l++) begin
                logic e_stall, e_ack, e_err;
                int   k;
                e_stall = ren[l] | wen[l];
                e_ack   = 1'b0;
                e_err   = 1'b0;
                if (m_busy[l]) begin
                    k = cyc - m_t0[l];
                    if (k <= LATS[l]) begin
                        e_stall = 1'b1;
                    end else begin
                        e_stall = 1'b0;
                        e_ack   = 1'b1;
                        e_err   = m_flt[l];
                    end
                end
                check(nm(l, "stall"), 32'(stall[l]), 32'(e_stall));
                check(nm(l, "ack"),   32'(ack[l]),   32'(e_ack));
                check(nm(l, "err"),   32'(err[l]),   32'(e_err));
                check(nm(l, "din"),   din[l],        m_din[l]);
                if (m_known[l][dbg_addr[l]]) check(nm(l, "debug_data"), dbg_data[l], m_ram[l][dbg_addr[l]]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int l = 0; l < NL; l++) dbg_addr[l] = AW'($urandom_range(0, 31));
    endtask

    // Present one request, scramble the lines while stalled, wait for ack, then leave IDLE with lines low.
    task automatic do_access(input int l, input logic r, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] wait_a, input bit junk,
                             output logic e_seen, output logic [31:0] din_seen);
        int n;
        n        = 0;
        e_seen   = 1'b0;
        din_seen = 32'd0;
        ren[l] = r; wen[l] = w; addr[l] = a; dout[l] = d;
        for (int i = 1; i <= LATS[l] + 4 && n == 0; i++) begin
            step();
            if (ack[l]) begin
                n        = i;
                e_seen   = err[l];
                din_seen = din[l];
            end else begin
                addr[l] = wait_a;
                dout[l] = $urandom;
                ren[l]  = 1'($urandom_range(0, 1));
                wen[l]  = 1'($urandom_range(0, 1));
            end
        end
        check(nm(l, "ack latency"), 32'(n), 32'(LATS[l] + 1));
        ren[l]  = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        wen[l]  = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        addr[l] = 32'($urandom_range(0, 31)) * 4;
        step();
        ren[l] = 1'b0;
        wen[l] = 1'b0;
    endtask

    task automatic wr(input int l, input logic [31:0] a, input logic [31:0] d, output logic e);
        logic [31:0] unused_din;
        do_access(l, 1'b0, 1'b1, a, d, a ^ 32'h4, 1'b0, e, unused_din);
    endtask

    task automatic rd(input int l, input logic [31:0] a, output logic e, output logic [31:0] q);
        do_access(l, 1'b1, 1'b0, a, 32'd0, a ^ 32'h4, 1'b0, e, q);
    endtask

    task automatic pin_debug(input int l, input logic [AW-1:0] w, input logic [31:0] exp, input string s);
        dbg_addr[l] = w;
        #1;
        check(nm(l, s), dbg_data[l], exp);
    endtask

    task automatic run_lane(input int l);
        logic        e;
        logic [31:0] q;
        int          k;
        for (int w = 0; w < 32; w++) wr(l, 32'(w) * 4, $urandom, e);

        wr(l, 32'h10, 32'hDEADBEEF, e);
        check(nm(l, "write err"), 32'(e), 32'd0);
        pin_debug(l, AW'(4), 32'hDEADBEEF, "debug after write");
        rd(l, 32'h10, e, q);
        check(nm(l, "read data"), q, 32'hDEADBEEF);
        wr(l, 32'h14, 32'h0BADF00D, e);
        check(nm(l, "din held over write"), din[l], 32'hDEADBEEF);

        wr(l, 32'h0, 32'h0000A000, e);
        wr(l, 32'h4, 32'h0000A001, e);
        wr(l, 32'h8, 32'h0000A002, e);
        pin_debug(l, AW'(0), 32'h0000A000, "b2b word0");
        pin_debug(l, AW'(2), 32'h0000A002, "b2b word2");

        rd(l, 32'h12, e, q);
        check(nm(l, "misaligned err"), 32'(e), 32'd1);
        check(nm(l, "misaligned din"), q, 32'd0);
        wr(l, 32'h1000, 32'hFFFF0000, e);
        check(nm(l, "range err"), 32'(e), 32'd1);
        pin_debug(l, AW'(0), 32'h0000A000, "range no write");
        do_access(l, 1'b1, 1'b1, 32'h8, 32'h12345678, 32'h8, 1'b0, e, q);
        check(nm(l, "ren&wen err"), 32'(e), 32'd1);
        check(nm(l, "ren&wen din"), q, 32'd0);
        pin_debug(l, AW'(2), 32'h0000A002, "ren&wen no write");

        do_access(l, 1'b0, 1'b1, 32'h4, 32'hC0FFEE11, 32'h8, 1'b1, e, q);
        pin_debug(l, AW'(1), 32'hC0FFEE11, "latched addr word1");
        pin_debug(l, AW'(2), 32'h0000A002, "latched addr word2");

        wr(l, 32'h20, 32'h11112222, e);
        rd(l, 32'h20, e, q);
        ren[l] = 1'b0; wen[l] = 1'b1; addr[l] = 32'h20; dout[l] = 32'h55AA55AA;
        k = (LATS[l] < 3) ? LATS[l] : 3;
        repeat (k) step();
        #2;
        ren[l] = 1'b0;
        wen[l] = 1'b0;
        rst    = 1'b0;
        #1;
        check(nm(l, "reset ack"),   32'(ack[l]),   32'd0);
        check(nm(l, "reset err"),   32'(err[l]),   32'd0);
        check(nm(l, "reset din"),   din[l],        32'd0);
        check(nm(l, "reset stall"), 32'(stall[l]), 32'd0);
        step();
        step();
        #2 rst = 1'b1;
        step();
        rd(l, 32'h20, e, q);
        check(nm(l, "read after reset"), q, 32'h11112222);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic        r, w;
            int          kind;
            kind = int'($urandom_range(0, 9));
            r    = 1'($urandom_range(0, 1));
            w    = ~r;
            a    = 32'($urandom_range(0, 31)) * 4;
            if (kind == 0) a = a + 32'($urandom_range(1, 3));
            if (kind == 1) a = $urandom | 32'h00001000;
            if (kind == 2) begin r = 1'b1; w = 1'b1; end
            do_access(l, r, w, a, $urandom, 32'($urandom_range(0, 31)) * 4, 1'($urandom_range(0, 1)), e, q);
            repeat ($urandom_range(0, 2)) step();
        end
    endtask

    initial begin
        ren = '0; wen = '0; addr = '0; dout = '0; dbg_addr = '0;
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        step();
        for (int l = 0; l < NL; l++) run_lane(l);
        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
